fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller that sequences the combinational, word-indexed instruction memory. It owns the program counter and drives the memory word address each cycle. Fetched words are captured with their PC into a 2-entry fetch queue, which is presented to decode through a valid/ready handshake. It also handles branch/jump redirects from later stages and detects program termination.

## Interface
- RESET_PC, 32'h0000_0000, byte PC loaded at reset; bits [1:0] ignored
- ADDR_W, 10, memory word-address width (1024 words)
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous, active-low reset
- Start  in  1  leaves IDLE; level or pulse
- ImemAddress  out  ADDR_W  word index = PC[ADDR_W+1:2]
- ImemInstruction  in  32  memory read data for ImemAddress, same cycle (combinational)
- IfValid  out  1  queue head valid
- IfInstruction  out  32  queue head instruction
- IfPC  out  32  byte PC of queue head
- IdReady  in  1  decode accepts head this cycle
- Redirect  in  1  flush and reload PC
- RedirectPC  in  32  new byte PC; bits [1:0] forced to 0
- Halted  out  1  halt reached and queue drained
- FetchCount  out  16  saturating count of pushes

## Operation
- States: IDLE, RUN, HALT.
- Reset state:
  - State IDLE, PC=RESET_PC, queue empty.
  - IfValid=0, IfInstruction=0, IfPC=0, Halted=0, FetchCount=0.
  - ImemAddress=RESET_PC[ADDR_W+1:2].
- IDLE:
  - Start=1 → RUN; no fetch in IDLE.
  - Redirect loads PC; state stays IDLE.
- Pop: IfValid & IdReady & !Redirect.
- Push: in RUN only, when (count<2 or pop) and !Redirect.
  - Pushes {PC, ImemInstruction}; then PC ← PC+4 (mod 2^32).
  - ImemAddress wraps 1023→0.
  - FetchCount increments per push, saturating at 16'hFFFF.
- Simultaneous push and pop: count unchanged, order preserved (FIFO).
- Queue full (count=2) with no pop: PC and ImemAddress frozen; no entry dropped or overwritten.
- Redirect (highest priority, any state):
  - Queue cleared; no push or pop that cycle.
  - PC ← {RedirectPC[31:2],2'b00}.
  - A head presented during the Redirect cycle is NOT accepted, even if IdReady=1.
  - From HALT → RUN, Halted=0. From RUN → stays RUN. From IDLE → stays IDLE.
- Halt entry (with macro, see Configuration): the pushed word is opcode 6'b000010 (j) with instr[25:0]==PC[27:2], i.e. a jump to itself.
  - The word is pushed; state → HALT; no further pushes.
- HALT: queue drains normally; Halted=1 when state HALT and count=0.
- Start is ignored outside IDLE.
- Rst low at any time: immediate return to reset values, regardless of the clock.

## Timing
- Start sampled at edge N → RUN after N.
- First push at N+1; IfValid=1 after N+1 with IfPC=RESET_PC.
- With IdReady held 1: one instruction per cycle, IfPC advancing by 4 each cycle.
- Redirect sampled at edge M: IfValid=0 after M; target word pushed at M+1; IfValid=1 after M+1. Redirect penalty: 1 bubble cycle.
- Backpressure release: the first pop after IdReady rises occurs in the same cycle, and a push also occurs that cycle.
- Halt word pushed at edge H; with IdReady=1 it pops at H+1; Halted=1 after H+1.
- Outputs are registered except ImemAddress, which is a direct slice of the PC register.

## Configuration
- HALT_DETECT_EN defined: self-jump detection and HALT state as described; Halted asserts after drain.
- Not defined: no halt detection, HALT unreachable, Halted tied 0. A self-jump is fetched repeatedly like any other word and FetchCount keeps counting until saturation.

## Test plan
- Reset check: Rst low mid-run with queue full → all outputs at reset values immediately; ImemAddress=0.
- Streaming: Start=1, IdReady=1, memory[0..3]=32'h3c120000, 32'h8e520000, 32'h3c130000, 32'h8e730004 → IfPC 0,4,8,12 on consecutive cycles with matching IfInstruction; FetchCount=4 after 4 pushes.
- Backpressure: IdReady=0 for 5 cycles in RUN → queue holds PC 0 and 4, ImemAddress frozen at 2, FetchCount frozen at 2. IdReady=1 → IfPC 0,4,8 with no gap or loss.
- Redirect with queue full and IdReady=1: RedirectPC=32'h0000_00B6 → head not accepted, IfValid=0 for one cycle, then IfPC=32'h0000_00B4, IfInstruction=memory[45].
- Halt (HALT_DETECT_EN defined): memory[62]=32'h0800003e, Redirect to 32'hF8 → one push of the 0xF8 word, then Halted=1 after drain; FetchCount stays constant. A following Redirect to 0 → Halted=0 and fetch resumes at 0.
- Halt (HALT_DETECT_EN undefined), same stimulus → IfPC=32'hF8 repeatedly; Halted stays 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, drives the word-indexed instruction memory
// and feeds decode from a 2-entry fetch queue over a valid/ready handshake.
//
// Ports:
//   Clk, Rst            clock, asynchronous active-low reset
//   Start               leaves IDLE (level or pulse)
//   ImemAddress         memory word index, a direct slice of the PC
//   ImemInstruction     combinational memory read data
//   IfValid/IfInstruction/IfPC  queue head presented to decode
//   IdReady             decode accepts the head this cycle
//   Redirect/RedirectPC flush the queue and reload the PC
//   Halted              halt reached and queue drained
//   FetchCount          saturating count of pushes
//
// Optional feature macro: HALT_DETECT_EN enables self-jump halt detection.
// Without it, HALT is unreachable and Halted is tied low.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 10
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  output logic [ADDR_W-1:0] ImemAddress,
  input  logic [31:0]       ImemInstruction,
  output logic              IfValid,
  output logic [31:0]       IfInstruction,
  output logic [31:0]       IfPC,
  input  logic              IdReady,
  input  logic              Redirect,
  input  logic [31:0]       RedirectPC,
  output logic              Halted,
  output logic [15:0]       FetchCount
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  logic [1:0]  state, state_n;
  logic [31:0] pc, pc_n;

  // Entry 0 is always the head; v1 implies v0.
  logic        v0, v1, v0_n, v1_n;
  logic [31:0] p0, p1, p0_n, p1_n;
  logic [31:0] i0, i1, i0_n, i1_n;

  logic pop, push, hit;

  assign ImemAddress   = pc[ADDR_W+1:2];
  assign IfValid       = v0;
  assign IfPC          = p0;
  assign IfInstruction = i0;

  assign pop  = v0 & IdReady & ~Redirect;
  assign push = (state == RUN) & (~v1 | pop) & ~Redirect;

`ifdef HALT_DETECT_EN
  // A j whose target is its own word address never leaves.
  assign hit = push
             & (ImemInstruction[31:26] == 6'b000010)
             & (ImemInstruction[25:0] == pc[27:2]);
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    pc_n = pc;
    if (Redirect)
      pc_n = RedirectPC & ~32'h3;
    else if (push)
      pc_n = pc + 32'd4;
  end

  always_comb begin
    state_n = state;
    unique case (1'b1)
      Redirect:
        if (state == HALT) state_n = RUN;
      hit:
        state_n = HALT;
      (!Redirect && state == IDLE && Start):
        state_n = RUN;
      default: ;
    endcase
  end

  // Pop shifts entry 1 down first, so a push then lands in the
  // first free slot and FIFO order holds for push+pop together.
  always_comb begin
    v0_n = v0;
    v1_n = v1;
    p0_n = p0;
    p1_n = p1;
    i0_n = i0;
    i1_n = i1;
    if (Redirect) begin
      v0_n = 1'b0;
      v1_n = 1'b0;
    end else begin
      if (pop) begin
        p0_n = p1;
        i0_n = i1;
        v0_n = v1;
        v1_n = 1'b0;
      end
      if (push) begin
        if (!v0_n) begin
          p0_n = pc;
          i0_n = ImemInstruction;
          v0_n = 1'b1;
        end else begin
          p1_n = pc;
          i1_n = ImemInstruction;
          v1_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= IDLE;
      pc         <= RESET_PC & ~32'h3;
      v0         <= 1'b0;
      v1         <= 1'b0;
      p0         <= '0;
      p1         <= '0;
      i0         <= '0;
      i1         <= '0;
      FetchCount <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      v0    <= v0_n;
      v1    <= v1_n;
      p0    <= p0_n;
      p1    <= p1_n;
      i0    <= i0_n;
      i1    <= i1_n;
      if (push && FetchCount != 16'hFFFF)
        FetchCount <= FetchCount + 16'd1;
    end
  end

`ifdef HALT_DETECT_EN
  logic halted;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)
      halted <= 1'b0;
    else
      halted <= (state_n == HALT) & ~v0_n;
  end

  assign Halted = halted;
`else
  assign Halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench for fetch_sequencer with a
// scoreboard of expected {pc, instruction} pairs popped on handshake.
module tb_fetch_sequencer;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic [9:0]  ImemAddress;
  logic [31:0] ImemInstruction;
  logic        IfValid;
  logic [31:0] IfInstruction;
  logic [31:0] IfPC;
  logic        IdReady;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        Halted;
  logic [15:0] FetchCount;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] mem [0:1023];
  int          checks = 0;
  int          errors = 0;

  fetch_sequencer dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .Start           (Start),
    .ImemAddress     (ImemAddress),
    .ImemInstruction (ImemInstruction),
    .IfValid         (IfValid),
    .IfInstruction   (IfInstruction),
    .IfPC            (IfPC),
    .IdReady         (IdReady),
    .Redirect        (Redirect),
    .RedirectPC      (RedirectPC),
    .Halted          (Halted),
    .FetchCount      (FetchCount)
  );

  assign ImemInstruction = mem[ImemAddress];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic expect_push(input logic [31:0] pc);
    ent_t e;
    e.pc  = pc;
    e.ins = mem[pc[11:2]];
    exp_q.push_back(e);
  endtask

  // Inputs only change at posedge+1, so at negedge the handshake
  // seen here is exactly what the next edge samples.
  always @(negedge Clk) begin
    if (Rst && IfValid && IdReady && !Redirect) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_empty observed_pc=%h expected=none", IfPC);
      end
      if (exp_q.size() != 0) begin
        ent_t e;
        e = exp_q.pop_front();
        chk("sb_pc", IfPC, e.pc);
        chk("sb_ins", IfInstruction, e.ins);
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++)
      mem[i] = 32'h2000_0000 | i;
    mem[0]  = 32'h3c120000;
    mem[1]  = 32'h8e520000;
    mem[2]  = 32'h3c130000;
    mem[3]  = 32'h8e730004;
    mem[62] = 32'h0800003e;

    Rst        = 1'b0;
    Start      = 1'b0;
    IdReady    = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = '0;
    tick(2);
    chk("rst_valid", {31'd0, IfValid}, 32'd0);
    chk("rst_ins", IfInstruction, 32'd0);
    chk("rst_pc", IfPC, 32'd0);
    chk("rst_halted", {31'd0, Halted}, 32'd0);
    chk("rst_count", {16'd0, FetchCount}, 32'd0);
    chk("rst_addr", {22'd0, ImemAddress}, 32'd0);
    Rst = 1'b1;

    // Redirect in IDLE loads the PC but never fetches.
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0013;
    tick(1);
    Redirect = 1'b0;
    chk("idle_redir_addr", {22'd0, ImemAddress}, 32'd4);
    tick(2);
    chk("idle_valid", {31'd0, IfValid}, 32'd0);
    chk("idle_count", {16'd0, FetchCount}, 32'd0);
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0000;
    tick(1);
    Redirect = 1'b0;
    chk("idle_back_addr", {22'd0, ImemAddress}, 32'd0);

    // Streaming.
    expect_push(32'd0);
    expect_push(32'd4);
    expect_push(32'd8);
    Start   = 1'b1;
    IdReady = 1'b1;
    tick(1);
    Start = 1'b0;
    chk("start_valid", {31'd0, IfValid}, 32'd0);
    tick(4);
    chk("stream_pc", IfPC, 32'd12);
    chk("stream_ins", IfInstruction, 32'h8e730004);
    chk("stream_count", {16'd0, FetchCount}, 32'd4);
    IdReady = 1'b0;
    chk("stream_sb", exp_q.size(), 32'd0);
    tick(2);
    chk("full_valid", {31'd0, IfValid}, 32'd1);
    chk("full_pc", IfPC, 32'd12);
    chk("full_addr", {22'd0, ImemAddress}, 32'd5);
    chk("full_count", {16'd0, FetchCount}, 32'd5);

    // Asynchronous reset mid-cycle with the queue full.
    #2;
    Rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, IfValid}, 32'd0);
    chk("arst_ins", IfInstruction, 32'd0);
    chk("arst_pc", IfPC, 32'd0);
    chk("arst_count", {16'd0, FetchCount}, 32'd0);
    chk("arst_addr", {22'd0, ImemAddress}, 32'd0);
    chk("arst_halted", {31'd0, Halted}, 32'd0);
    exp_q.delete();
    tick(1);
    Rst = 1'b1;

    // Backpressure.
    expect_push(32'd0);
    expect_push(32'd4);
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    tick(5);
    chk("bp_pc", IfPC, 32'd0);
    chk("bp_addr", {22'd0, ImemAddress}, 32'd2);
    chk("bp_count", {16'd0, FetchCount}, 32'd2);
    IdReady = 1'b1;
    tick(1);
    chk("bp_rel_count", {16'd0, FetchCount}, 32'd3);
    chk("bp_rel_pc", IfPC, 32'd4);
    tick(1);
    chk("bp_head8", IfPC, 32'd8);
    chk("bp_sb", exp_q.size(), 32'd0);

    // Redirect with the queue full and decode ready.
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_00B6;
    expect_push(32'h0000_00B4);
    tick(1);
    Redirect = 1'b0;
    chk("redir_valid", {31'd0, IfValid}, 32'd0);
    chk("redir_addr", {22'd0, ImemAddress}, 32'd45);
    chk("redir_count", {16'd0, FetchCount}, 32'd4);
    tick(1);
    chk("redir_tgt_valid", {31'd0, IfValid}, 32'd1);
    chk("redir_tgt_pc", IfPC, 32'h0000_00B4);
    chk("redir_tgt_ins", IfInstruction, 32'h2000_002D);
    tick(1);
    chk("redir_sb", exp_q.size(), 32'd0);

`ifdef HALT_DETECT_EN
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_00F8;
    expect_push(32'h0000_00F8);
    tick(1);
    Redirect = 1'b0;
    chk("halt_addr", {22'd0, ImemAddress}, 32'd62);
    tick(1);
    chk("halt_pc", IfPC, 32'h0000_00F8);
    chk("halt_pre", {31'd0, Halted}, 32'd0);
    tick(1);
    chk("halt_set", {31'd0, Halted}, 32'd1);
    tick(3);
    chk("halt_hold", {31'd0, Halted}, 32'd1);
    chk("halt_valid", {31'd0, IfValid}, 32'd0);
    chk("halt_count", {16'd0, FetchCount}, 32'd7);
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0000;
    expect_push(32'd0);
    tick(1);
    Redirect = 1'b0;
    chk("unhalt", {31'd0, Halted}, 32'd0);
    tick(1);
    chk("resume_pc", IfPC, 32'd0);
    chk("resume_count", {16'd0, FetchCount}, 32'd8);
    tick(1);
    IdReady = 1'b0;
    chk("resume_sb", exp_q.size(), 32'd0);
`else
    for (int k = 0; k < 3; k++) begin
      Redirect   = 1'b1;
      RedirectPC = 32'h0000_00F8;
      expect_push(32'h0000_00F8);
      tick(1);
      Redirect = 1'b0;
      tick(1);
      chk("selfj_pc", IfPC, 32'h0000_00F8);
      chk("selfj_halted", {31'd0, Halted}, 32'd0);
      tick(1);
    end
    IdReady = 1'b0;
    chk("selfj_count", {16'd0, FetchCount}, 32'd12);
    chk("selfj_sb", exp_q.size(), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
